mult_sched: RTL
===============

// Module: mult_sched
// PURPOSE
//  Round-robin scheduler sharing one sequential N-bit multiplier (load/a/b -> p/valid)
//  between NREQ requesters. Grants one requester, pulses the multiplier load, waits
//  for valid, returns the 2N-bit product with a done pulse, then re-arbitrates.
//  Timeout guards against a multiplier that never asserts valid.
// PARAMETERS
//  N        4    operand width; product is 2*N
//  NREQ     4    number of requesters (2..8)
//  TIMEOUT  64   max cycles in WAIT before abort (>= 2)
// PORTS
//  clk      in   1        system clock, rising edge
//  rst      in   1        asynchronous reset, active-high
//  req      in   NREQ     per-requester request level; hold until own done
//  req_a    in   NREQ*N   operand a, requester i at [i*N +: N]
//  req_b    in   NREQ*N   operand b, requester i at [i*N +: N]
//  gnt      out  NREQ     one-hot grant, held from grant through DONE
//  done     out  NREQ     one-cycle pulse on granted requester's bit
//  result   out  2*N      product, valid while done pulses; held until next capture
//  err      out  1        one-cycle pulse with done when the op timed out
//  m_load   out  1        multiplier load, one-cycle pulse
//  m_a      out  N        multiplier operand a, registered
//  m_b      out  N        multiplier operand b, registered
//  m_p      in   2*N      multiplier product
//  m_valid  in   1        multiplier result valid (level)
// BEHAVIOUR
//  - Reset (async): state=IDLE; gnt, done, err, m_load, m_a, m_b, result = 0;
//    rr pointer = NREQ-1, so requester 0 has highest priority first.
//  - FSM: IDLE -> LOAD -> SETTLE -> WAIT -> DONE -> IDLE.
//  - IDLE: at the edge where any req bit is 1, pick first set bit searching
//    ptr+1, ptr+2, ... (mod NREQ); register gnt, m_a/m_b from that slice; go to LOAD.
//    No req: stay in IDLE, all outputs hold (done/err/m_load = 0).
//  - LOAD: m_load=1 for exactly this cycle -> SETTLE.
//  - SETTLE: m_valid ignored (stale valid from previous op) -> WAIT; timeout counter cleared.
//  - WAIT: on edge with m_valid=1, result<=m_p -> DONE. Counter increments each
//    WAIT cycle; when it reaches TIMEOUT-1 without valid, result<=0, err flagged -> DONE.
//  - DONE: done[g]=1 (g=granted index), err=1 if timed out, 1 cycle; next edge:
//    gnt<=0, ptr<=g, -> IDLE.
//  - Min latency: req high in IDLE cycle t -> m_load at t+1 -> done at t+3+L,
//    L = cycles from SETTLE until m_valid sampled high (L>=1).
//  - m_a/m_b stable from LOAD through DONE; operand changes on req_a/req_b after
//    grant have no effect on the current op.
//  - Requester must drop req in the cycle after its done; req still high in the
//    following IDLE is a new request (rr ptr gives other requesters priority).
//  - req dropped mid-op: op still completes, done still pulses; no abort.
//  - Simultaneous requests: exactly one grant; others wait; fairness: each active
//    requester is served within NREQ ops.
//  - gnt is always one-hot or zero; done/err never asserted outside DONE.
//  - Reset mid-operation: immediate return to IDLE, m_load deasserted; the
//    multiplier is not reset by this block, next load restarts it.
//  - Arithmetic: no truncation; result is m_p as presented (2*N bits).
// TESTING
//  1. Single req0, a=2,b=4 -> m_load one pulse, m_a=2,m_b=4; done[0] pulse, result=8, err=0.
//  2. req1 a=3,b=15 and req2 a=15,b=15 same cycle -> req1 served first (result=45),
//     then req2 (result=225); gnt never two-hot.
//  3. All four req held continuously -> grant order 0,1,2,3,0,... ; each done once per round.
//  4. Multiplier model never asserts m_valid -> done+err pulse after TIMEOUT WAIT cycles,
//     result=0; next request completes normally.
//  5. Stale m_valid held high from previous op -> SETTLE ignores it; result taken only
//     from WAIT sample (check new product, e.g. 15*15=225 not previous 45).
//  6. Assert rst during WAIT -> gnt/done/m_load = 0 at once; after release req0 a=2,b=4 -> 8.

Source files
------------

// File: rtl/mult_sched.sv
// Round-robin scheduler that shares one sequential multiplier between NREQ requesters.
// One op runs at a time: grant, load pulse, wait for valid (or timeout), done pulse.
module mult_sched #(
  parameter int N       = 4,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [2*N-1:0]    result,
  output logic              err,
  output logic              m_load,
  output logic [N-1:0]      m_a,
  output logic [N-1:0]      m_b,
  input  logic [2*N-1:0]    m_p,
  input  logic              m_valid
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [N-1:0]      m_a_q, m_a_d;
  logic [N-1:0]      m_b_q, m_b_d;
  logic [2*N-1:0]    result_q, result_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tout_q, tout_d;

  logic [N-1:0]      a_sl [NREQ];
  logic [N-1:0]      b_sl [NREQ];
  logic [PW-1:0]     pick;
  logic              pick_vld;
  int                idx;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign a_sl[gi] = req_a[gi*N +: N];
      assign b_sl[gi] = req_b[gi*N +: N];
    end
  endgenerate

  // Scan from farthest to nearest after ptr so the nearest set request wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (req[idx]) begin
        pick     = PW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    m_a_d    = m_a_q;
    m_b_d    = m_b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    tout_d   = tout_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = NREQ'(1) << pick;
          gidx_d  = pick;
          m_a_d   = a_sl[pick];
          m_b_d   = b_sl[pick];
          tout_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD:   state_d = S_SETTLE;
      // m_valid here may still belong to the previous op, so it is not looked at.
      S_SETTLE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (m_valid) begin
          result_d = m_p;
          state_d  = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          result_d = '0;
          tout_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        ptr_d   = gidx_q;
        state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      ptr_q    <= PW'(NREQ - 1);
      gidx_q   <= '0;
      m_a_q    <= '0;
      m_b_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      m_a_q    <= m_a_d;
      m_b_q    <= m_b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      tout_q   <= tout_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = (state_q == S_DONE) ? gnt_q : '0;
  assign err    = (state_q == S_DONE) && tout_q;
  assign m_load = (state_q == S_LOAD);
  assign m_a    = m_a_q;
  assign m_b    = m_b_q;
  assign result = result_q;

endmodule
